// File: rtl/bus_map_pkg.sv
// rtl/bus_map_pkg.sv - region/state enums and I/O page offsets for bus_slave_ctrl
package bus_map_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_VGA, REG_UART, REG_NONE} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_e;

  localparam logic [7:0] VGA_OFF   = 8'h00;
  localparam logic [7:0] VGA_SPAN  = 8'd4;
  localparam logic [7:0] UART_OFF  = 8'h10;
  localparam logic [7:0] UART_SPAN = 8'd2;
  localparam logic [7:0] RD_FILL   = 8'hFF;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational address-to-region decode for bus_slave_ctrl
module bus_addr_decode
  import bus_map_pkg::*;
#(
  parameter logic [15:0] IO_BASE = 16'hFE00
) (
  input  logic [15:0] i_addr,
  output region_e     o_region
);

  logic [7:0] vga_rel;
  logic [7:0] uart_rel;

  // Offsets relative to each window; 8-bit wrap turns a two-sided range test into one compare.
  assign vga_rel  = i_addr[7:0] - VGA_OFF;
  assign uart_rel = i_addr[7:0] - UART_OFF;

  always_comb begin
    o_region = REG_RAM;
    if (i_addr[15:8] == IO_BASE[15:8]) begin
      if (vga_rel < VGA_SPAN)        o_region = REG_VGA;
      else if (uart_rel < UART_SPAN) o_region = REG_UART;
      else                           o_region = REG_NONE;
    end
  end

endmodule

// File: rtl/bus_slave_ctrl.sv
// rtl/bus_slave_ctrl.sv - single-master bus controller routing to SRAM, VGA and UART slaves
// Optional BUS_TIMEOUT_EN: UART accesses give up after TIMEOUT cycles and set sticky o_bus_err.
module bus_slave_ctrl
  import bus_map_pkg::*;
#(
  parameter int          RAM_WAIT = 1,
  parameter logic [15:0] IO_BASE  = 16'hFE00,
  parameter int          TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  input  logic        i_cs,
  input  logic        i_we,
  output logic        o_ack,
  output logic [15:0] o_ram_addr,
  output logic [7:0]  o_ram_dat,
  input  logic [7:0]  i_ram_dat,
  output logic        o_ram_cs,
  output logic        o_ram_we,
  output logic [1:0]  o_vga_addr,
  output logic [7:0]  o_vga_dat,
  input  logic [7:0]  i_vga_dat,
  output logic        o_vga_cs,
  output logic        o_vga_we,
  output logic        o_uart_addr,
  output logic [7:0]  o_uart_dat,
  input  logic [7:0]  i_uart_dat,
  output logic        o_uart_cs,
  output logic        o_uart_we,
  input  logic        i_uart_ack,
  output logic        o_bus_err
);

  localparam logic [15:0] RAM_LAST = 16'(RAM_WAIT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  region_e     region_d;
  region_e     region_q;
  state_e      state_q;
  logic [15:0] addr_q;
  logic [7:0]  wdat_q;
  logic [7:0]  rdat_q;
  logic        we_q;
  logic [15:0] cnt_q;
  logic        in_access;

  bus_addr_decode #(.IO_BASE(IO_BASE)) u_decode (
    .i_addr   (i_addr),
    .o_region (region_d)
  );

`ifdef BUS_TIMEOUT_EN
  logic err_q;
  assign o_bus_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
  assign o_bus_err      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      region_q <= REG_RAM;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef BUS_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cs) begin
            addr_q   <= i_addr;
            wdat_q   <= i_dat;
            we_q     <= i_we;
            region_q <= region_d;
            cnt_q    <= '0;
            if (region_d == REG_NONE) begin
              state_q <= ST_ACK;
              if (!i_we) rdat_q <= RD_FILL;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_q + 16'd1;
          case (region_q)
            REG_RAM: begin
              if (cnt_q == RAM_LAST) begin
                if (!we_q) rdat_q <= i_ram_dat;
                state_q <= ST_ACK;
              end
            end
            REG_VGA: begin
              if (!we_q) rdat_q <= i_vga_dat;
              state_q <= ST_ACK;
            end
            REG_UART: begin
              // A late ack on the final timeout cycle still wins over the timeout.
              if (i_uart_ack) begin
                if (!we_q) rdat_q <= i_uart_dat;
                state_q <= ST_ACK;
              end
`ifdef BUS_TIMEOUT_EN
              else if (cnt_q == TO_LAST) begin
                rdat_q  <= RD_FILL;
                err_q   <= 1'b1;
                state_q <= ST_ACK;
              end
`endif
            end
            default: state_q <= ST_ACK;
          endcase
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_access   = (state_q == ST_ACCESS);
  assign o_ack       = (state_q == ST_ACK);
  assign o_dat       = rdat_q;

  assign o_ram_cs    = in_access && (region_q == REG_RAM);
  assign o_vga_cs    = in_access && (region_q == REG_VGA);
  assign o_uart_cs   = in_access && (region_q == REG_UART);
  assign o_ram_we    = o_ram_cs  && we_q;
  assign o_vga_we    = o_vga_cs  && we_q;
  assign o_uart_we   = o_uart_cs && we_q;

  assign o_ram_addr  = addr_q;
  assign o_ram_dat   = wdat_q;
  assign o_vga_addr  = addr_q[1:0];
  assign o_vga_dat   = wdat_q;
  assign o_uart_addr = addr_q[0];
  assign o_uart_dat  = wdat_q;

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// tb/tb_bus_slave_ctrl.sv - randomized self-checking bench for bus_slave_ctrl against a latency/data model
module tb_bus_slave_ctrl;

  localparam int          RAM_WAIT = 1;
  localparam logic [15:0] IO_BASE  = 16'hFE00;
  localparam int          TIMEOUT  = 16;
  localparam int          LIMIT    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdat;
  logic [7:0]  rdat;
  logic        cs, we, ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdat, ram_rdat;
  logic        ram_cs, ram_we;
  logic [1:0]  vga_addr;
  logic [7:0]  vga_wdat, vga_rdat;
  logic        vga_cs, vga_we;
  logic        uart_addr;
  logic [7:0]  uart_wdat, uart_rdat;
  logic        uart_cs, uart_we, uart_ack;
  logic        bus_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_dat = 8'h00;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  bus_slave_ctrl #(.RAM_WAIT(RAM_WAIT), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(rdat),
    .i_cs(cs), .i_we(we), .o_ack(ack),
    .o_ram_addr(ram_addr), .o_ram_dat(ram_wdat), .i_ram_dat(ram_rdat),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we),
    .o_vga_addr(vga_addr), .o_vga_dat(vga_wdat), .i_vga_dat(vga_rdat),
    .o_vga_cs(vga_cs), .o_vga_we(vga_we),
    .o_uart_addr(uart_addr), .o_uart_dat(uart_wdat), .i_uart_dat(uart_rdat),
    .o_uart_cs(uart_cs), .o_uart_we(uart_we), .i_uart_ack(uart_ack),
    .o_bus_err(bus_err)
  );

  // 0 = RAM, 1 = VGA, 2 = UART, 3 = unmapped
  function automatic int model_region(input int a);
    int off;
    off = a - int'(IO_BASE);
    if (off < 0 || off > 255) return 0;
    if (off < 4) return 1;
    if (off == 16 || off == 17) return 2;
    return 3;
  endfunction

  // Issue one request from an idle bus; ud = UART ack delay in cycles (0 = never ack).
  task automatic do_txn(input string nm, input logic [15:0] a, input logic [7:0] d,
                        input logic w, input int ud);
    int r, exp_lat, exp_cs, lat, k, cs_cnt, other, bad;
    r = model_region(int'(a));
    ram_rdat  = 8'($urandom);
    vga_rdat  = 8'($urandom);
    uart_rdat = 8'($urandom);
    lat = -1; k = 0; cs_cnt = 0; other = 0; bad = 0;
    case (r)
      0: begin exp_lat = 2 + RAM_WAIT; exp_cs = 1 + RAM_WAIT; if (!w) exp_dat = ram_rdat; end
      1: begin exp_lat = 2; exp_cs = 1; if (!w) exp_dat = vga_rdat; end
      2: begin
        if (ud == 0) begin
          exp_lat = TIMEOUT + 1; exp_cs = TIMEOUT; exp_dat = 8'hFF; exp_err = 1'b1;
        end else begin
          exp_lat = ud + 1; exp_cs = ud; if (!w) exp_dat = uart_rdat;
        end
      end
      default: begin exp_lat = 1; exp_cs = 0; if (!w) exp_dat = 8'hFF; end
    endcase
    addr = a; wdat = d; we = w; cs = 1'b1;
    while (lat < 0 && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (k == 1) cs = 1'b0;
      if (ram_cs) begin
        if (r == 0) begin
          cs_cnt++;
          if (ram_addr !== a || ram_wdat !== d || ram_we !== w) bad++;
        end else other++;
      end else if (ram_we) bad++;
      if (vga_cs) begin
        if (r == 1) begin
          cs_cnt++;
          if (vga_addr !== a[1:0] || vga_wdat !== d || vga_we !== w) bad++;
        end else other++;
      end else if (vga_we) bad++;
      if (uart_cs) begin
        if (r == 2) begin
          cs_cnt++;
          if (uart_addr !== a[0] || uart_wdat !== d || uart_we !== w) bad++;
        end else other++;
      end else if (uart_we) bad++;
      if (ack) lat = k;
      uart_ack = (r == 2 && ud != 0 && k == ud);
    end
    uart_ack = 1'b0;
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
    checks++; if (cs_cnt !== exp_cs) begin errors++; $display("FAIL %s cs_cycles: got %0d want %0d", nm, cs_cnt, exp_cs); end
    checks++; if (other !== 0) begin errors++; $display("FAIL %s stray_cs: got %0d want 0", nm, other); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s slave_fields: got %0d bad cycles want 0", nm, bad); end
    checks++; if (rdat !== exp_dat) begin errors++; $display("FAIL %s o_dat: got %02h want %02h", nm, rdat, exp_dat); end
    checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL %s bus_err: got %0b want %0b", nm, bus_err, exp_err); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL %s ack_width: got %0b want 0", nm, ack); end
  endtask

  task automatic test_reset;
    cs = 0; we = 0; addr = '0; wdat = '0; uart_ack = 0;
    ram_rdat = '0; vga_rdat = '0; uart_rdat = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, ram_cs, ram_we, vga_cs, vga_we, uart_cs, uart_we, bus_err} !== 8'h00 || rdat !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%08b dat=%02h want ctl=00000000 dat=00",
               {ack, ram_cs, ram_we, vga_cs, vga_we, uart_cs, uart_we, bus_err}, rdat);
    end
    rst = 1'b0;
    exp_dat = 8'h00; exp_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_txn("ram_rd_1234",   16'h1234, 8'h00, 1'b0, 0);
    do_txn("vga_wr_fe02",   16'hFE02, 8'h41, 1'b1, 0);
    do_txn("uart_rd_fe11",  16'hFE11, 8'h00, 1'b0, 5);
    do_txn("unmap_rd_fe20", 16'hFE20, 8'h00, 1'b0, 0);
    do_txn("ram_rd_fdff",   16'hFDFF, 8'h00, 1'b0, 0);
    do_txn("ram_wr_ff00",   16'hFF00, 8'h9C, 1'b1, 0);
    do_txn("unmap_wr_fe04", 16'hFE04, 8'h77, 1'b1, 0);
    do_txn("vga_rd_fe03",   16'hFE03, 8'h00, 1'b0, 0);
    do_txn("unmap_rd_fe12", 16'hFE12, 8'h00, 1'b0, 0);
    do_txn("uart_wr_fe10",  16'hFE10, 8'hA5, 1'b1, 1);
  endtask

  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = 16'($urandom); if (a[15:8] == IO_BASE[15:8]) a[15] = 1'b0; end
        1: a = IO_BASE + 16'($urandom_range(0, 3));
        2: a = IO_BASE + 16'h10 + 16'($urandom_range(0, 1));
        default: a = IO_BASE + (($urandom_range(0, 1) == 0) ? 16'($urandom_range(4, 15))
                                                              : 16'($urandom_range(18, 255)));
      endcase
      do_txn("random", a, 8'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
    end
  endtask

  task automatic test_uart_wait;
`ifdef BUS_TIMEOUT_EN
    do_txn("uart_timeout", 16'hFE11, 8'h00, 1'b0, 0);
    do_txn("err_sticky",   16'h0100, 8'h00, 1'b0, 0);
    test_reset;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", bus_err); end
`else
    do_txn("uart_long_wait", 16'hFE10, 8'h00, 1'b0, 30);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_tied: got %0b want 0", bus_err); end
`endif
  endtask

  task automatic test_reset_abort;
    int acks;
    acks = 0;
    ram_rdat = 8'hC3;
    addr = 16'h2000; we = 1'b0; cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    @(negedge clk);
    checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL abort_pre_cs: got %0b want 1", ram_cs); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ram_cs !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL abort_post: got cs=%0b ack=%0b want 0 0", ram_cs, ack); end
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL abort_dat: got %02h want 00", rdat); end
    exp_dat = 8'h00; exp_err = 1'b0;
    repeat (6) begin @(negedge clk); if (ack || ram_cs) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", acks); end
  endtask

  task automatic test_back_to_back;
    int ack_at[$];
    int k;
    k = 0;
    ram_rdat = 8'h6E;
    addr = 16'h4321; we = 1'b0; cs = 1'b1;
    while (ack_at.size() < 4 && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (ack) ack_at.push_back(k);
    end
    cs = 1'b0;
    checks++; if (ack_at.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", ack_at.size()); end
    checks++; if (ack_at.size() > 0 && ack_at[0] !== 2 + RAM_WAIT) begin errors++; $display("FAIL b2b_first: got %0d want %0d", ack_at[0], 2 + RAM_WAIT); end
    for (int i = 1; i < ack_at.size(); i++) begin
      checks++;
      if (ack_at[i] - ack_at[i-1] !== 3 + RAM_WAIT) begin
        errors++; $display("FAIL b2b_gap: got %0d want %0d", ack_at[i] - ack_at[i-1], 3 + RAM_WAIT);
      end
    end
    checks++; if (rdat !== 8'h6E) begin errors++; $display("FAIL b2b_dat: got %02h want 6e", rdat); end
    exp_dat = 8'h6E;
    repeat (2 + RAM_WAIT) @(negedge clk);
    checks++; if (ack !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL b2b_release: got ack=%0b cs=%0b want 0 0", ack, ram_cs); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_uart_wait;
    test_reset_abort;
    test_back_to_back;
    do_txn("after_b2b", 16'hFE01, 8'h00, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
